// File: rtl/addressable_debouncer_n.sv
// Purpose : per-channel switch debouncer (SPDT or SPST) with latched change flags,
//           an active-low interrupt and an address-selected tri-state read port.
// Latency : SYNC_STAGES + DEBOUNCE cycles from a clean input edge to the stable level.
// Backpressure : none; reads are combinational and change flags clear on read.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   in         : 2 contacts per channel, in[2i] = R contact, in[2i+1] = S contact
//   addr, abus : chip strap and shared address bus; selected when equal and rd = 1
//   rd         : read strobe, reg_sel selects levels (0) or change flags (1)
//   out        : tri-state data, high-Z unless selected
//   irq_n      : low while any change flag is set
module addressable_debouncer_n #(
    parameter int CHANNELS    = 8,
    parameter int ADDR_W      = 3,
    parameter int DEBOUNCE    = 16,
    parameter int SPDT        = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2*CHANNELS-1:0] in,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [ADDR_W-1:0]     abus,
    input  logic                  rd,
    input  logic                  reg_sel,
    output logic [CHANNELS-1:0]   out,
    output logic                  irq_n
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    // The count accepts the new level on the cycle it would have reached DEBOUNCE.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    logic [SYNC_STAGES-1:0][2*CHANNELS-1:0] sync_q, sync_d;
    logic [CHANNELS-1:0][CW-1:0]            cnt_q, cnt_d;
    logic [CHANNELS-1:0]                    stable_q, stable_d;
    logic [CHANNELS-1:0]                    chg_q, chg_d;
    logic                                   irq_n_q, irq_n_d;

    logic [CHANNELS-1:0] s_bit, r_bit, raw, toggle;
    logic                sel, clr;

    assign sel = (abus == addr) && rd;
    assign clr = sel && reg_sel;

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = in;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end

        s_bit    = '0;
        r_bit    = '0;
        raw      = '0;
        toggle   = '0;
        stable_d = stable_q;
        cnt_d    = '0;

        for (int i = 0; i < CHANNELS; i++) begin
            s_bit[i] = sync_q[SYNC_STAGES-1][2*i+1];
            r_bit[i] = sync_q[SYNC_STAGES-1][2*i];
            if (SPDT != 0) begin
                // Transit gap (both open) or fault (both closed) holds the stable
                // level, which also clears any count in progress.
                raw[i] = (s_bit[i] ^ r_bit[i]) ? s_bit[i] : stable_q[i];
            end else begin
                raw[i] = s_bit[i];
            end

            if (raw[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    toggle[i]   = 1'b1;
                    stable_d[i] = ~stable_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end

        // A toggle on the same edge as a clearing read keeps its flag.
        chg_d   = (clr ? '0 : chg_q) | toggle;
        irq_n_d = ~|chg_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
            chg_q    <= '0;
            irq_n_q  <= 1'b1;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            chg_q    <= chg_d;
            irq_n_q  <= irq_n_d;
        end
    end

    assign out   = sel ? (reg_sel ? chg_q : stable_q) : {CHANNELS{1'bz}};
    assign irq_n = irq_n_q;

endmodule

// File: tb/tb_addressable_debouncer_n.sv
module tb_addressable_debouncer_n;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in_v;
    logic [15:0] in_c;
    logic [2:0]  strap_a;
    logic [2:0]  abus;
    logic        rd;
    logic        reg_sel;
    wire  [7:0]  out_a, out_b, out_c;
    wire         irq_a, irq_b, irq_c;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Undriven data lines float high so a released bus reads as 8'hFF.
    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (out_a[g]);
        pullup (out_b[g]);
        pullup (out_c[g]);
    end

    addressable_debouncer_n #(.CHANNELS(8), .ADDR_W(3), .DEBOUNCE(16), .SPDT(1), .SYNC_STAGES(2)) u_a (
        .clk(clk), .rst_n(rst_n), .in(in_v), .addr(strap_a), .abus(abus),
        .rd(rd), .reg_sel(reg_sel), .out(out_a), .irq_n(irq_a));

    addressable_debouncer_n #(.CHANNELS(8), .ADDR_W(3), .DEBOUNCE(16), .SPDT(1), .SYNC_STAGES(2)) u_b (
        .clk(clk), .rst_n(rst_n), .in(in_v), .addr(3'd6), .abus(abus),
        .rd(rd), .reg_sel(reg_sel), .out(out_b), .irq_n(irq_b));

    addressable_debouncer_n #(.CHANNELS(8), .ADDR_W(3), .DEBOUNCE(16), .SPDT(0), .SYNC_STAGES(2)) u_c (
        .clk(clk), .rst_n(rst_n), .in(in_c), .addr(3'd7), .abus(abus),
        .rd(rd), .reg_sel(reg_sel), .out(out_c), .irq_n(irq_c));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int ch, input logic s, input logic r);
        in_v[2*ch+1] = s;
        in_v[2*ch]   = r;
    endtask

    // Look at the change flags of instance A without an edge passing.
    task automatic peek_chg(output logic [7:0] v);
        reg_sel = 1'b1;
        #1;
        v = out_a;
        reg_sel = 1'b0;
        #1;
    endtask

    task automatic clear_chg();
        reg_sel = 1'b1;
        tick();
        reg_sel = 1'b0;
        #1;
    endtask

    logic [7:0] v;

    initial begin
        rst_n = 1'b0; in_v = '0; in_c = '0; strap_a = 3'd5; abus = 3'd5;
        rd = 1'b1; reg_sel = 1'b0;

        // Reset with toggling inputs
        for (int k = 0; k < 6; k++) begin
            in_v = 16'($urandom);
            in_c = 16'($urandom);
            tick();
        end
        check("rst_out", out_a, 8'h00);
        check("rst_irq", {7'd0, irq_a}, 8'h01);
        abus = 3'd4;
        #1;
        check("rst_out_z", out_a, 8'hFF);
        in_v = '0; in_c = '0;
        rst_n = 1'b1;
        strap_a = 3'd2; abus = 3'd2;
        repeat (5) tick();
        check("idle_stable", out_a, 8'h00);

        // Clean press on channel 3
        set_ch(3, 1'b1, 1'b0);
        repeat (17) tick();
        check("press_17", out_a, 8'h00);
        tick();
        check("press_18", out_a, 8'h08);
        peek_chg(v);
        check("press_chg", v, 8'h08);
        tick();
        check("press_irq", {7'd0, irq_a}, 8'h00);
        clear_chg();
        check("clr_irq", {7'd0, irq_a}, 8'h01);
        peek_chg(v);
        check("clr_chg", v, 8'h00);

        // Bouncing channel 0: 5-cycle phases never reach the threshold
        for (int p = 0; p < 8; p++) begin
            set_ch(0, (p % 2) == 0, (p % 2) == 1);
            repeat (5) tick();
            check("bounce", out_a, 8'h08);
        end
        set_ch(0, 1'b1, 1'b0);
        repeat (17) tick();
        check("bounce_hold_17", out_a, 8'h08);
        tick();
        check("bounce_hold_18", out_a, 8'h09);
        clear_chg();

        // Transit gap on channel 1
        set_ch(1, 1'b1, 1'b0);
        repeat (18) tick();
        check("gap_setup", out_a, 8'h0B);
        clear_chg();
        set_ch(1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            repeat (25) tick();
            check("gap_stable", out_a, 8'h0B);
            peek_chg(v);
            check("gap_chg", v, 8'h00);
        end
        set_ch(1, 1'b1, 1'b0);
        repeat (30) tick();
        check("gap_end_stable", out_a, 8'h0B);
        peek_chg(v);
        check("gap_end_chg", v, 8'h00);

        // Clear-on-read racing a toggle: ch0 toggles one edge before ch2
        set_ch(0, 1'b0, 1'b1);
        tick();
        set_ch(2, 1'b1, 1'b0);
        repeat (17) tick();
        reg_sel = 1'b1;
        #1;
        check("race_read", out_a, 8'h01);
        tick();
        check("race_after", out_a, 8'h04);
        reg_sel = 1'b0;
        #1;
        check("race_irq", {7'd0, irq_a}, 8'h00);
        check("race_stable", out_a, 8'h0E);
        clear_chg();
        peek_chg(v);
        check("race_clr", v, 8'h00);
        check("race_clr_irq", {7'd0, irq_a}, 8'h01);

        // Shared bus select
        abus = 3'd6;
        #1;
        check("addr_a_z", out_a, 8'hFF);
        check("addr_b", out_b, 8'h0E);
        rd = 1'b0;
        #1;
        check("rd0_b_z", out_b, 8'hFF);
        check("rd0_a_z", out_a, 8'hFF);
        rd = 1'b1;
        strap_a = 3'd6;
        #1;
        check("strap_move", out_a, 8'h0E);
        strap_a = 3'd2;
        abus = 3'd2;
        #1;
        check("strap_back_b_z", out_b, 8'hFF);
        check("strap_back_irq", {7'd0, irq_a}, 8'h01);

        // SPST instance: R contact alone has no effect
        abus = 3'd7;
        for (int k = 0; k < 40; k++) begin
            in_c[0] = ~in_c[0];
            in_c[4] = ~in_c[4];
            tick();
        end
        check("spst_r_only", out_c, 8'h00);
        in_c[1] = 1'b1;
        repeat (17) tick();
        check("spst_17", out_c, 8'h00);
        tick();
        check("spst_18", out_c, 8'h01);

        // Reset in the middle of a count
        abus = 3'd2;
        in_v = '0;
        set_ch(4, 1'b1, 1'b0);
        repeat (10) tick();
        rst_n = 1'b0;
        in_v = '0;
        tick();
        rst_n = 1'b1;
        repeat (30) tick();
        check("midrst_stable", out_a, 8'h00);
        check("midrst_irq", {7'd0, irq_a}, 8'h01);
        peek_chg(v);
        check("midrst_chg", v, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
